// File: rtl/acq_mux.sv
// Multi-channel acquisition multiplexer: per-channel sample FIFOs filled on a
// shared prescaled tick, drained round-robin as 3-byte frames (A<ch>, MSB, LSB).
module acq_mux #(
  parameter int NCH        = 4,
  parameter int NBITS      = 12,
  parameter int DEPTH_LOG2 = 4,
  parameter int PREBITS    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*NBITS-1:0]   samples,
  input  logic [NCH-1:0]         enable,
  input  logic [PREBITS-1:0]     pre,
  input  logic                   clear_ovf,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [NCH-1:0]         overflow,
  output logic                   tick
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;

  typedef logic [DEPTH_LOG2:0] ptr_t;
  typedef enum logic [1:0] {IDLE, HDR, MSB, LSB} state_t;

  state_t             state;
  logic [PREBITS-1:0] cnt;
  logic [NBITS-1:0]   mem [NCH][DEPTH];
  ptr_t               wr_ptr [NCH];
  ptr_t               rd_ptr [NCH];
  logic [NCH-1:0]     empty;
  logic [NCH-1:0]     full;
  logic [NCH-1:0]     push;
  logic [NCH-1:0]     pop;
  logic [NCH-1:0]     accept;
  logic               any_pending;
  logic [CHW-1:0]     last;
  logic [CHW-1:0]     sel;
  logic [15:0]        hold;

  assign any_pending = ~&empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign empty[gi]  = (wr_ptr[gi] == rd_ptr[gi]);
    assign full[gi]   = (wr_ptr[gi][DEPTH_LOG2] != rd_ptr[gi][DEPTH_LOG2]) &&
                        (wr_ptr[gi][DEPTH_LOG2-1:0] == rd_ptr[gi][DEPTH_LOG2-1:0]);
    assign push[gi]   = tick && enable[gi];
    assign pop[gi]    = (state == IDLE) && any_pending && (sel == CHW'(gi));
    assign accept[gi] = push[gi] && (!full[gi] || pop[gi]);
  end

  // Round-robin: first non-empty channel after the one served last.
  always_comb begin
    logic           found;
    logic [CHW-1:0] idx;
    sel   = last;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CHW'((int'(last) + k) % NCH);
      if (!found && !empty[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tick     <= 1'b0;
      overflow <= '0;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      if (cnt >= pre) begin
        tick <= 1'b1;
        cnt  <= '0;
      end else begin
        tick <= 1'b0;
        cnt  <= cnt + 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !accept[i]) overflow[i] <= 1'b1;
        else if (clear_ovf)        overflow[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (accept[i]) mem[i][wr_ptr[i][DEPTH_LOG2-1:0]] <= samples[i*NBITS +: NBITS];
    end
  end

  // Frame serialiser; the header is built straight from sel at pop time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= CHW'(NCH - 1);
      hold     <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pending) begin
            hold     <= 16'(mem[sel][rd_ptr[sel][DEPTH_LOG2-1:0]]);
            last     <= sel;
            tx_data  <= {4'hA, 4'(sel)};
            tx_valid <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (tx_ready) begin
            tx_data <= hold[15:8];
            state   <= MSB;
          end
        end
        MSB: begin
          if (tx_ready) begin
            tx_data <= hold[7:0];
            state   <= LSB;
          end
        end
        LSB: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_mux.sv
// Randomised bench for acq_mux against a queue-based frame/prescaler model.
module tb_acq_mux;

  localparam int NCH        = 4;
  localparam int NBITS      = 12;
  localparam int DEPTH_LOG2 = 4;
  localparam int PREBITS    = 10;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH*NBITS-1:0] samples = '0;
  logic [NCH-1:0]       enable = '0;
  logic [PREBITS-1:0]   pre = '0;
  logic                 clear_ovf = 1'b0;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready = 1'b1;
  logic [NCH-1:0]       overflow;
  logic                 tick;

  acq_mux #(.NCH(NCH), .NBITS(NBITS), .DEPTH_LOG2(DEPTH_LOG2), .PREBITS(PREBITS)) dut (
    .clk(clk), .rst(rst), .samples(samples), .enable(enable), .pre(pre),
    .clear_ovf(clear_ovf), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .overflow(overflow), .tick(tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: sample queues, pending frame bytes, prescaler.
  int             q [NCH][$];
  int             exp_bytes [$];
  int             busy;
  int             last;
  int             mcnt;
  bit             mtick;
  bit [NCH-1:0]   movf;
  bit             sent_any;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) q[c].delete();
    exp_bytes.delete();
    busy = 0; last = NCH - 1; mcnt = 0; mtick = 0; movf = '0; sent_any = 0;
  endtask

  task automatic model_edge();
    int pop_ch;
    int s;
    int idx;
    pop_ch = -1;
    if (busy == 0) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (last + k) % NCH;
        if (pop_ch < 0 && q[idx].size() > 0) pop_ch = idx;
      end
    end
    if (busy > 0) begin
      if (tx_ready) begin
        $display("tx byte %02h", exp_bytes[0]);
        void'(exp_bytes.pop_front());
        busy--;
      end
    end else if (pop_ch >= 0) begin
      s = q[pop_ch].pop_front();
      exp_bytes.push_back(8'hA0 | pop_ch);
      exp_bytes.push_back((s >> 8) & 8'hFF);
      exp_bytes.push_back(s & 8'hFF);
      busy = 3; last = pop_ch; sent_any = 1;
    end
    for (int c = 0; c < NCH; c++) begin
      if (mtick && enable[c] && q[c].size() >= DEPTH) movf[c] = 1'b1;
      else begin
        if (mtick && enable[c]) q[c].push_back(int'(samples[c*NBITS +: NBITS]));
        if (clear_ovf) movf[c] = 1'b0;
      end
    end
    mtick = (mcnt >= int'(pre));
    mcnt  = mtick ? 0 : mcnt + 1;
  endtask

  task automatic check_outputs();
    check_val("tick", tick, mtick);
    check_val("tx_valid", tx_valid, busy > 0);
    check_val("overflow", overflow, movf);
    if (busy > 0)       check_val("tx_data", tx_data, exp_bytes[0]);
    else if (!sent_any) check_val("tx_data_idle", tx_data, 0);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    if (!rst) check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_sample(input int c, input logic [NBITS-1:0] v);
    samples[c*NBITS +: NBITS] = v;
  endtask

  task automatic randomize_samples();
    for (int c = 0; c < NCH; c++) set_sample(c, NBITS'($urandom));
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_tick", tick, 0);
    check_val("rst_valid", tx_valid, 0);
    check_val("rst_data", tx_data, 0);
    check_val("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Single channel, steady stream.
    enable = 4'b0001; pre = 3; tx_ready = 1'b1; set_sample(0, 12'hABC);
    run(60);

    // All four channels, round-robin.
    enable = 4'b1111; pre = 20;
    for (int c = 0; c < NCH; c++) set_sample(c, NBITS'((c + 1) * 12'h111));
    run(200);
    enable = '0; run(100);

    // Backpressure fills FIFO 0 and overflows it, then drains in order.
    enable = 4'b0001; pre = 0; tx_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      set_sample(0, NBITS'($urandom));
      step();
    end
    enable = '0; tx_ready = 1'b1; run(90);

    // Clear collides with a fresh drop, then clear alone.
    enable = 4'b0001; tx_ready = 1'b0; run(25);
    clear_ovf = 1'b1; run(3);
    enable = '0; clear_ovf = 1'b1; run(2);
    clear_ovf = 1'b0; tx_ready = 1'b1; run(80);

    // Prescaler lowered mid-count.
    pre = 100; enable = 4'b0010; set_sample(1, 12'h5A5);
    guard = 0;
    while (mcnt != 50 && guard < 300) begin step(); guard++; end
    check_val("pre_reach_cnt50", guard < 300, 1);
    pre = 10; run(50);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      randomize_samples();
      if (i % 60 == 0) pre = PREBITS'($urandom_range(0, 7));
      if (i % 40 == 0) enable = NCH'($urandom);
      tx_ready  = ($urandom_range(0, 3) != 0);
      clear_ovf = ($urandom_range(0, 19) == 0);
      step();
    end
    clear_ovf = 1'b0; enable = '0; tx_ready = 1'b1; run(120);

    // Reset during MSB with an overflow flag already set.
    enable = 4'b0001; pre = 0; tx_ready = 1'b0; run(40);
    pre = 3; tx_ready = 1'b1;
    guard = 0;
    while (busy != 2 && guard < 100) begin step(); guard++; end
    check_val("reach_msb", guard < 100, 1);
    check_val("pre_rst_ovf", overflow[0], 1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_valid", tx_valid, 0);
    check_val("async_rst_ovf", overflow, 0);
    check_val("async_rst_data", tx_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_sample(0, 12'h3C7);
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
